// File: rtl/s_axis_cc_pktbuf_if.sv
// AXI-Stream completer-completion beat bundle shared by the input (_a) and
// output (_b) sides of the packet buffer.
interface s_axis_cc_pktbuf_if #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [32:0]           tuser;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/s_axis_cc_pktbuf.sv
// Store-and-forward packet buffer between the CC adapter and the hard IP CC port:
// packets are released only once complete and clean; discontinued or oversize packets vanish.
module s_axis_cc_pktbuf #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 32,
  parameter int DEPTH      = 32
) (
  input  logic               user_clk,
  input  logic               user_reset_n,
  s_axis_cc_pktbuf_if.slave  s_axis_cc_a,
  s_axis_cc_pktbuf_if.master s_axis_cc_b,
  output logic               drop_pulse,
  output logic               oversize_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [32:0]           user;
  } beat_t;

  typedef enum logic {WR_FILL, WR_DROP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_SEND} rd_state_t;

  beat_t     mem [DEPTH];
  beat_t     beat_in;
  beat_t     out_q;
  logic      out_valid;

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic [PW-1:0] wr_spec, wr_spec_nxt;
  logic [PW-1:0] wr_commit, wr_commit_nxt;
  logic [PW-1:0] pkt_start, pkt_start_nxt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] spec_inc;
  logic [PW-1:0] pkt_cnt;
  logic [PW-1:0] level;

  logic disc, disc_nxt;
  logic drop_nxt, oversize_nxt;
  logic mem_we;
  logic a_accept;
  logic rd_avail, rd_load, out_free, b_xfer;

  assign beat_in = '{data: s_axis_cc_a.tdata, keep: s_axis_cc_a.tkeep,
                     last: s_axis_cc_a.tlast, user: s_axis_cc_a.tuser};

  // The beat held in the output register still occupies a slot, so the level
  // counts it; tready_a therefore drops once DEPTH beats are held in total.
  assign level    = wr_spec - rd_ptr + PW'(out_valid);
  assign spec_inc = wr_spec + PW'(1);
  assign pkt_cnt  = spec_inc - pkt_start;

  assign s_axis_cc_a.tready = user_reset_n &&
                              ((wr_state == WR_DROP) || (level < PW'(DEPTH)));
  assign a_accept = s_axis_cc_a.tvalid && s_axis_cc_a.tready;

  // NOTE: every signal written here gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    wr_state_nxt  = wr_state;
    wr_spec_nxt   = wr_spec;
    wr_commit_nxt = wr_commit;
    pkt_start_nxt = pkt_start;
    disc_nxt      = disc;
    drop_nxt      = 1'b0;
    oversize_nxt  = oversize_err;
    mem_we        = 1'b0;
    case (wr_state)
      WR_FILL: begin
        if (a_accept) begin
          mem_we      = 1'b1;
          wr_spec_nxt = spec_inc;
          disc_nxt    = disc | s_axis_cc_a.tuser[0];
          if (s_axis_cc_a.tlast) begin
            disc_nxt = 1'b0;
            if (disc | s_axis_cc_a.tuser[0]) begin
              wr_spec_nxt = pkt_start;
              drop_nxt    = 1'b1;
            end else begin
              wr_commit_nxt = spec_inc;
              pkt_start_nxt = spec_inc;
            end
          end else if (pkt_cnt == PW'(DEPTH)) begin
            // The packet can never fit: discard what was stored and swallow the rest.
            wr_spec_nxt  = pkt_start;
            disc_nxt     = 1'b0;
            oversize_nxt = 1'b1;
            wr_state_nxt = WR_DROP;
          end
        end
      end
      WR_DROP: begin
        if (a_accept && s_axis_cc_a.tlast) begin
          drop_nxt     = 1'b1;
          wr_state_nxt = WR_FILL;
        end
      end
      default: wr_state_nxt = WR_FILL;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      wr_state     <= WR_FILL;
      wr_spec      <= '0;
      wr_commit    <= '0;
      pkt_start    <= '0;
      disc         <= 1'b0;
      drop_pulse   <= 1'b0;
      oversize_err <= 1'b0;
    end else begin
      wr_state     <= wr_state_nxt;
      wr_spec      <= wr_spec_nxt;
      wr_commit    <= wr_commit_nxt;
      pkt_start    <= pkt_start_nxt;
      disc         <= disc_nxt;
      drop_pulse   <= drop_nxt;
      oversize_err <= oversize_nxt;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone decide
  // which entries are valid, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge user_clk) begin
    if (mem_we) mem[wr_spec[AW-1:0]] <= beat_in;
  end

  assign rd_avail = (rd_ptr != wr_commit);
  assign b_xfer   = out_valid && s_axis_cc_b.tready;
  assign out_free = !out_valid || s_axis_cc_b.tready;

  always_comb begin
    rd_state_nxt = rd_state;
    rd_load      = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (rd_avail) begin
          rd_load      = 1'b1;
          rd_state_nxt = RD_SEND;
        end
      end
      RD_SEND: begin
        rd_load = rd_avail && out_free;
        if (b_xfer && out_q.last && !rd_avail) rd_state_nxt = RD_IDLE;
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      rd_state  <= RD_IDLE;
      rd_ptr    <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      rd_state <= rd_state_nxt;
      if (rd_load) begin
        out_q     <= mem[rd_ptr[AW-1:0]];
        out_valid <= 1'b1;
        rd_ptr    <= rd_ptr + PW'(1);
      end else if (s_axis_cc_b.tready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign s_axis_cc_b.tdata  = out_q.data;
  assign s_axis_cc_b.tkeep  = out_q.keep;
  assign s_axis_cc_b.tlast  = out_q.last;
  assign s_axis_cc_b.tuser  = out_q.user;
  assign s_axis_cc_b.tvalid = out_valid;

endmodule

// File: tb/tb_s_axis_cc_pktbuf.sv
// Directed bench for s_axis_cc_pktbuf: hand-built packets, a bench-side expected
// queue, and a posedge monitor that collects output transfers and protocol slips.
module tb_s_axis_cc_pktbuf;

  localparam int DW    = 128;
  localparam int KW    = 4;
  localparam int DEPTH = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [32:0]   user;
  } beat_t;

  logic user_clk = 1'b0;
  logic user_reset_n;
  logic drop_pulse;
  logic oversize_err;

  always #5 user_clk = ~user_clk;

  s_axis_cc_pktbuf_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) a_if ();
  s_axis_cc_pktbuf_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) b_if ();

  s_axis_cc_pktbuf #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH(DEPTH)) dut (
    .user_clk     (user_clk),
    .user_reset_n (user_reset_n),
    .s_axis_cc_a  (a_if.slave),
    .s_axis_cc_b  (b_if.master),
    .drop_pulse   (drop_pulse),
    .oversize_err (oversize_err)
  );

  // ---------------- output monitor ----------------
  beat_t b_cur;
  assign b_cur = {b_if.tdata, b_if.tkeep, b_if.tlast, b_if.tuser};

  beat_t rx[$];
  int    rx_cyc[$];
  int    cyc        = 0;
  int    hold_err   = 0;
  int    gap_err    = 0;
  int    stall_seen = 0;
  int    drop_cnt   = 0;
  beat_t held;
  bit    stalled    = 1'b0;
  bit    in_pkt     = 1'b0;

  always @(posedge user_clk) begin
    cyc = cyc + 1;
    if (!user_reset_n) begin
      stalled = 1'b0;
      in_pkt  = 1'b0;
    end else begin
      if (stalled && (b_cur !== held)) hold_err++;
      if (in_pkt && !b_if.tvalid) gap_err++;
      if (b_if.tvalid && b_if.tready) begin
        rx.push_back(b_cur);
        rx_cyc.push_back(cyc);
      end
      if (drop_pulse) drop_cnt++;
      stalled = b_if.tvalid && !b_if.tready;
      if (stalled) stall_seen++;
      held   = b_cur;
      in_pkt = b_if.tvalid && !(b_if.tready && b_if.tlast);
    end
  end

  // ---------------- checking helpers ----------------
  int    n_vec   = 0;
  int    n_err   = 0;
  int    rx_base = 0;
  beat_t exp_q[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  function automatic beat_t mk_beat(int pid, int i, int nb, bit disc);
    beat_t b;
    b.data = {16'hC0DE, 16'(pid), 32'(i), 32'(pid * 131 + i * 17), ~32'(pid ^ (i << 8))};
    b.keep = (i == nb - 1) ? (4'hF >> (pid % 4)) : 4'hF;
    b.last = (i == nb - 1);
    b.user = {16'(pid), 16'(i), disc};
    return b;
  endfunction

  // Sends beats 0..n_send-1 of an nb-beat packet; beat disc_at carries tuser[0]=1.
  task automatic send_pkt(input int pid, input int nb, input int n_send, input int disc_at,
                          input bit keep_exp, output int stalls);
    beat_t bt;
    bit    acc;
    stalls = 0;
    for (int i = 0; i < n_send; i++) begin
      bt = mk_beat(pid, i, nb, i == disc_at);
      a_if.tdata  = bt.data;
      a_if.tkeep  = bt.keep;
      a_if.tlast  = bt.last;
      a_if.tuser  = bt.user;
      a_if.tvalid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
        @(negedge user_clk);
        acc = a_if.tready;
        @(posedge user_clk);
        #1;
        if (!acc) stalls++;
      end
      chk($sformatf("accept_p%0d_b%0d", pid, i), acc, 1);
      if (keep_exp) exp_q.push_back(bt);
    end
    a_if.tvalid = 1'b0;
    a_if.tlast  = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int t = 0; t < budget && (rx.size() - rx_base) < n; t++) step();
  endtask

  task automatic cmp_rx(input string tag);
    int n;
    n = rx.size() - rx_base;
    chk({tag, "_count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      chk($sformatf("%s_beat%0d", tag, i), rx[rx_base + i], exp_q[i]);
    rx_base = rx.size();
    exp_q.delete();
  endtask

  function automatic int count_gaps(input int first, input int last_idx);
    int g = 0;
    for (int i = first + 1; i <= last_idx && i < rx_cyc.size(); i++)
      if (rx_cyc[i] != rx_cyc[i-1] + 1) g++;
    return g;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int st, lat, k, d0, h0, g0, s0;

    user_reset_n = 1'b0;
    a_if.tdata   = '0;
    a_if.tkeep   = '0;
    a_if.tlast   = 1'b0;
    a_if.tuser   = '0;
    a_if.tvalid  = 1'b0;
    b_if.tready  = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_tready_a", a_if.tready, 0);
    chk("rst_tvalid_b", b_if.tvalid, 0);
    chk("rst_tlast_b", b_if.tlast, 0);
    chk("rst_drop", drop_pulse, 0);
    chk("rst_oversize", oversize_err, 0);
    user_reset_n = 1'b1;
    step();
    chk("post_rst_tready_a", a_if.tready, 1);
    chk("post_rst_tdata_b", b_if.tdata, 0);

    // 3-beat packet, sink always ready
    b_if.tready = 1'b1;
    send_pkt(1, 3, 3, -1, 1'b1, st);
    chk("saf_no_early_beat", rx.size() - rx_base, 0);
    lat = 0;
    while (!b_if.tvalid && lat < 5) begin
      step();
      lat++;
    end
    chk("tvalid_latency_le2", lat <= 2, 1);
    wait_rx(3, 20);
    chk("p1_contiguous", count_gaps(rx_base, rx_base + 2), 0);
    cmp_rx("p1");

    // Discontinued 4-beat packet, then a clean one
    d0 = drop_cnt;
    send_pkt(2, 4, 4, 1, 1'b0, st);
    repeat (4) step();
    chk("disc_no_output", rx.size() - rx_base, 0);
    chk("disc_drop_cycles", drop_cnt - d0, 1);
    chk("disc_no_oversize", oversize_err, 0);
    send_pkt(3, 2, 2, -1, 1'b1, st);
    wait_rx(2, 20);
    cmp_rx("p3");

    // 33-beat oversize packet, then a 2-beat packet
    d0 = drop_cnt;
    send_pkt(4, 33, 33, -1, 1'b0, st);
    chk("oversize_no_stall", st, 0);
    chk("oversize_flag", oversize_err, 1);
    repeat (4) step();
    chk("oversize_drop_cycles", drop_cnt - d0, 1);
    chk("oversize_no_output", rx.size() - rx_base, 0);
    send_pkt(5, 2, 2, -1, 1'b1, st);
    wait_rx(2, 20);
    cmp_rx("p5");
    chk("oversize_sticky", oversize_err, 1);

    // 8-beat packet with a toggling sink
    h0 = hold_err;
    g0 = gap_err;
    s0 = stall_seen;
    b_if.tready = 1'b0;
    send_pkt(6, 8, 8, -1, 1'b1, st);
    for (int t = 0; t < 40 && (rx.size() - rx_base) < 8; t++) begin
      b_if.tready = ~b_if.tready;
      step();
    end
    b_if.tready = 1'b1;
    chk("toggle_stalls_seen", (stall_seen - s0) > 0, 1);
    chk("toggle_hold_stable", hold_err - h0, 0);
    chk("toggle_no_gap", gap_err - g0, 0);
    cmp_rx("p6");

    // Fill with 1-beat packets against a stalled sink
    b_if.tready = 1'b0;
    step();
    k = 0;
    for (int p = 0; p < 40; p++) begin
      if (!a_if.tready) break;
      send_pkt(7 + p, 1, 1, -1, 1'b1, st);
      k++;
    end
    chk("fill_count", k, DEPTH);
    repeat (2) step();
    chk("full_tready_a", a_if.tready, 0);
    b_if.tready = 1'b1;
    step();
    b_if.tready = 1'b0;
    chk("after_pulse_tready_a", a_if.tready, 1);
    b_if.tready = 1'b1;
    wait_rx(DEPTH, 80);
    chk("drain_back_to_back", count_gaps(rx_base + 1, rx_base + DEPTH - 1), 0);
    cmp_rx("fill");

    // Reset with packets in flight on both sides
    b_if.tready = 1'b0;
    send_pkt(40, 3, 3, -1, 1'b0, st);
    step();
    b_if.tready = 1'b1;
    step();
    b_if.tready = 1'b0;
    send_pkt(41, 4, 2, -1, 1'b0, st);
    a_if.tvalid  = 1'b1;
    user_reset_n = 1'b0;
    step();
    chk("midrst_tready_a", a_if.tready, 0);
    chk("midrst_tvalid_b", b_if.tvalid, 0);
    chk("midrst_tlast_b", b_if.tlast, 0);
    chk("midrst_drop", drop_pulse, 0);
    chk("midrst_oversize", oversize_err, 0);
    a_if.tvalid = 1'b0;
    step();
    user_reset_n = 1'b1;
    step();
    chk("rel_tready_a", a_if.tready, 1);
    chk("rel_tvalid_b", b_if.tvalid, 0);
    chk("rel_tdata_b", b_if.tdata, 0);
    chk("rel_tkeep_b", b_if.tkeep, 0);
    chk("rel_tuser_b", b_if.tuser, 0);
    rx_base = rx.size();
    exp_q.delete();
    b_if.tready = 1'b1;
    send_pkt(42, 2, 2, -1, 1'b1, st);
    wait_rx(2, 20);
    repeat (6) step();
    cmp_rx("p42");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
